// File: rtl/vga_pkg.sv
// Shared VGA definitions: RGB332 pixel type, frame geometry
// and the draw-layer arbiter FSM encoding.
package vga_pkg;

  typedef logic [7:0] rgb_t;

  localparam rgb_t RGB_WHITE = 8'hFF;

  localparam int FRAME_W = 640;
  localparam int FRAME_H = 480;

  typedef enum logic [1:0] {
    WAIT_SYNC,
    ACTIVE,
    REPORT
  } arb_state_t;

endpackage

// File: rtl/priority_select.sv
// Combinational fixed-priority picker.
// Lowest asserted request index wins.
module priority_select #(
  parameter int N_LAYERS = 4
) (
  input  logic [N_LAYERS-1:0] req_i,
  output logic                valid_o,
  output logic [3:0]          idx_o
);

  always_comb begin
    valid_o = 1'b0;
    idx_o   = 4'd0;
    for (int k = N_LAYERS - 1; k >= 0; k--) begin
      if (req_i[k]) begin
        valid_o = 1'b1;
        idx_o   = 4'(k);
      end
    end
  end

endmodule

// File: rtl/draw_layer_arbiter.sv
// Per-pixel layer arbiter with one registered stage and
// per-frame player collision accumulation and reporting.
module draw_layer_arbiter
  import vga_pkg::*;
#(
  parameter int   N_LAYERS    = 4,
  parameter rgb_t DEFAULT_RGB = RGB_WHITE
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic                  startOfFrame,
  input  logic [N_LAYERS-1:0]   layerDrawReq,
  input  logic [8*N_LAYERS-1:0] layerRGB,
  input  logic [7:0]            bgRGB,
  input  logic                  boardersDrawReq,
  output logic [7:0]            RGBOut,
  output logic [3:0]            winnerIdx,
  output logic                  collisionPulse,
  output logic [N_LAYERS-1:0]   collisionMask
);

  logic                sel_vld;
  logic [3:0]          sel_idx;
  rgb_t                pix_d;
  logic [3:0]          win_d;
  logic [N_LAYERS-1:0] hit;

  rgb_t                rgb_q;
  logic [3:0]          win_q;
  arb_state_t          state_q;
  logic [N_LAYERS-1:0] acc_q;
  logic [N_LAYERS-1:0] mask_q;
  logic                pulse_q;

  priority_select #(
    .N_LAYERS(N_LAYERS)
  ) u_sel (
    .req_i  (layerDrawReq),
    .valid_o(sel_vld),
    .idx_o  (sel_idx)
  );

  always_comb begin
    pix_d = bgRGB;
    for (int k = 0; k < N_LAYERS; k++) begin
      if (sel_vld && sel_idx == 4'(k)) begin
        pix_d = layerRGB[8*k +: 8];
      end
    end
    win_d = sel_vld ? sel_idx : 4'(N_LAYERS);
  end

  // Bit 0 is player vs border; bit k is player vs layer k.
  always_comb begin
    hit    = layerDrawReq & {N_LAYERS{layerDrawReq[0]}};
    hit[0] = layerDrawReq[0] & boardersDrawReq;
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      rgb_q   <= DEFAULT_RGB;
      win_q   <= 4'(N_LAYERS);
      state_q <= WAIT_SYNC;
      acc_q   <= '0;
      mask_q  <= '0;
      pulse_q <= 1'b0;
    end else begin
      rgb_q   <= pix_d;
      win_q   <= win_d;
      pulse_q <= 1'b0;
      unique case (state_q)
        WAIT_SYNC: begin
          if (startOfFrame) begin
            acc_q   <= '0;
            state_q <= ACTIVE;
          end
        end
        ACTIVE, REPORT: begin
          if (startOfFrame) begin
            mask_q  <= acc_q;
            pulse_q <= |acc_q;
            acc_q   <= hit;
            state_q <= REPORT;
          end else begin
            acc_q   <= acc_q | hit;
            state_q <= ACTIVE;
          end
        end
        default: state_q <= WAIT_SYNC;
      endcase
    end
  end

  assign RGBOut         = rgb_q;
  assign winnerIdx      = win_q;
  assign collisionPulse = pulse_q;
  assign collisionMask  = mask_q;

endmodule

// File: tb/tb_draw_layer_arbiter.sv
// Scoreboard bench for draw_layer_arbiter: frame-level model
// pushes expected outputs, monitor pops and compares.
module tb_draw_layer_arbiter;

  localparam int NL = 4;

  logic            clk = 1'b0;
  logic            resetN;
  logic            startOfFrame;
  logic [NL-1:0]   layerDrawReq;
  logic [8*NL-1:0] layerRGB;
  logic [7:0]      bgRGB;
  logic            boardersDrawReq;
  logic [7:0]      RGBOut;
  logic [3:0]      winnerIdx;
  logic            collisionPulse;
  logic [NL-1:0]   collisionMask;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [7:0]    rgb;
    logic [3:0]    win;
    logic          pulse;
    logic [NL-1:0] mask;
  } exp_t;

  exp_t sb[$];

  draw_layer_arbiter #(
    .N_LAYERS   (NL),
    .DEFAULT_RGB(8'hFF)
  ) dut (
    .clk            (clk),
    .resetN         (resetN),
    .startOfFrame   (startOfFrame),
    .layerDrawReq   (layerDrawReq),
    .layerRGB       (layerRGB),
    .bgRGB          (bgRGB),
    .boardersDrawReq(boardersDrawReq),
    .RGBOut         (RGBOut),
    .winnerIdx      (winnerIdx),
    .collisionPulse (collisionPulse),
    .collisionMask  (collisionMask)
  );

  always #5 clk = ~clk;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, req, $time);
    end
  endtask

  // Reference model: frame-level bookkeeping of which
  // collisions the player saw since the last frame start.
  bit            synced = 0;
  logic [NL-1:0] seen   = '0;
  logic [NL-1:0] m_mask = '0;

  always @(posedge clk) begin
    exp_t          e;
    logic [NL-1:0] h;
    int            w;
    if (!resetN) begin
      synced = 0;
      seen   = '0;
      m_mask = '0;
      e.rgb  = 8'hFF;
      e.win  = 4'(NL);
      e.pulse = 1'b0;
      e.mask = '0;
    end else begin
      w = NL;
      for (int k = NL - 1; k >= 0; k--)
        if (layerDrawReq[k]) w = k;
      e.rgb = (w == NL) ? bgRGB : layerRGB[8*w +: 8];
      e.win = 4'(w);
      h = '0;
      if (layerDrawReq[0]) begin
        h[0] = boardersDrawReq;
        for (int k = 1; k < NL; k++) h[k] = layerDrawReq[k];
      end
      e.pulse = 1'b0;
      if (startOfFrame) begin
        if (synced) begin
          m_mask  = seen;
          e.pulse = (seen != 0);
          seen    = h;
        end else begin
          synced = 1;
          seen   = '0;
        end
      end else if (synced) begin
        seen = seen | h;
      end
      e.mask = m_mask;
    end
    sb.push_back(e);
  end

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check("RGBOut", 32'(RGBOut), 32'(e.rgb));
      check("winnerIdx", 32'(winnerIdx), 32'(e.win));
      check("collisionPulse", 32'(collisionPulse), 32'(e.pulse));
      check("collisionMask", 32'(collisionMask), 32'(e.mask));
    end
  end

  task automatic drive(input logic [NL-1:0] req,
                       input logic sof,
                       input logic brd);
    layerDrawReq    = req;
    startOfFrame    = sof;
    boardersDrawReq = brd;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive('0, 1'b0, 1'b0);
  endtask

  initial begin
    resetN          = 1'b0;
    startOfFrame    = 1'b0;
    layerDrawReq    = '0;
    boardersDrawReq = 1'b0;
    bgRGB           = 8'h1C;
    layerRGB        = {8'h5A, 8'h03, 8'hE0, 8'h92};
    idle(3);
    check("rst_rgb", 32'(RGBOut), 32'hFF);
    check("rst_win", 32'(winnerIdx), 32'd4);
    check("rst_mask", 32'(collisionMask), 32'd0);
    resetN = 1'b1;
    idle(1);
    check("bg_rgb", 32'(RGBOut), 32'h1C);
    check("bg_win", 32'(winnerIdx), 32'd4);
    drive(4'b0110, 1'b0, 1'b0);
    check("l1_rgb", 32'(RGBOut), 32'hE0);
    check("l1_win", 32'(winnerIdx), 32'd1);
    drive(4'b1111, 1'b0, 1'b0);
    check("l0_rgb", 32'(RGBOut), 32'h92);
    check("l0_win", 32'(winnerIdx), 32'd0);

    drive('0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) drive(4'b0001, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) drive(4'b1001, 1'b0, 1'b0);
    idle(3);
    drive('0, 1'b1, 1'b0);
    check("f1_pulse", 32'(collisionPulse), 32'd1);
    check("f1_mask", 32'(collisionMask), 32'h9);
    idle(1);
    check("f1_pulse_end", 32'(collisionPulse), 32'd0);
    check("f1_mask_hold", 32'(collisionMask), 32'h9);
    idle(5);
    drive('0, 1'b1, 1'b0);
    check("f2_pulse", 32'(collisionPulse), 32'd0);
    check("f2_mask", 32'(collisionMask), 32'h0);

    idle(4);
    drive(4'b0101, 1'b1, 1'b0);
    check("sof_ov_mask", 32'(collisionMask), 32'h0);
    idle(4);
    drive('0, 1'b1, 1'b0);
    check("sof_ov_next", 32'(collisionMask), 32'h4);
    check("sof_ov_pulse", 32'(collisionPulse), 32'd1);

    drive(4'b0011, 1'b0, 1'b0);
    resetN = 1'b0;
    idle(2);
    resetN = 1'b1;
    idle(2);
    drive(4'b0011, 1'b1, 1'b0);
    check("rst_sof_pulse", 32'(collisionPulse), 32'd0);
    check("rst_sof_mask", 32'(collisionMask), 32'h0);
    drive(4'b1001, 1'b0, 1'b0);
    idle(2);
    drive('0, 1'b1, 1'b0);
    check("post_rst_mask", 32'(collisionMask), 32'h8);
    check("post_rst_pulse", 32'(collisionPulse), 32'd1);

    for (int i = 0; i < 3000; i++) begin
      resetN   = ($urandom_range(0, 299) != 0);
      bgRGB    = 8'($urandom);
      layerRGB = 32'($urandom);
      drive(4'($urandom),
            ($urandom_range(0, 19) == 0),
            1'($urandom));
    end
    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
